ntsc_bram_writer: RTL
=====================

NTSC_BRAM_WRITER -- requirements
Module: ntsc_bram_writer

Interface
REQ-001 SHALL have parameter LOGSIZE, default 14, meaning frame-buffer address width, matching the downstream BRAM.
REQ-002 SHALL have parameter WIDTH, default 1, meaning stored bits per pixel; legal range 1..8.
REQ-003 SHALL have parameter H_PIX, default 128, meaning stored pixels per line.
REQ-004 SHALL have parameter V_LINES, default 128, meaning stored lines per frame; H_PIX*V_LINES <= 2^LOGSIZE.
REQ-005 SHALL have parameter HDEC, default 2, meaning keep one of every HDEC active input pixels per line.
REQ-006 SHALL have parameter THRESH, default 8'd128, meaning luma threshold used when WIDTH==1.
REQ-007 SHALL have port clk, input, 1, the single clock for all logic.
REQ-008 SHALL have port reset_n, input, 1, reset: asynchronous, active-low.
REQ-009 SHALL have port enable, input, 1, arms capture while high.
REQ-010 SHALL have port luma, input, 8, decoded NTSC luma sample.
REQ-011 SHALL have port dv, input, 1, luma valid strobe.
REQ-012 SHALL have port fvh, input, 3, {field, vblank, hblank} from the decoder.
REQ-013 SHALL have port addr, output, LOGSIZE, BRAM write address.
REQ-014 SHALL have port din, output, WIDTH, BRAM write data.
REQ-015 SHALL have port we, output, 1, BRAM write enable.
REQ-016 SHALL have port busy, output, 1, high in WAIT_FIELD and CAPTURE.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_FIELD, CAPTURE, DONE.
REQ-019 SHALL go IDLE->WAIT_FIELD on the cycle enable is sampled high.
REQ-020 SHALL go WAIT_FIELD->CAPTURE on a vblank falling edge (prev v=1, current v=0) with field==0; pixel column x, line y and decimation phase all clear to 0.
REQ-021 In CAPTURE, a pixel SHALL be accepted only when dv=1, v=0 and h=0; dv while h=1 or v=1 is ignored.
REQ-022 For each accepted pixel, a write SHALL occur when phase==0 and x<H_PIX: addr=y*H_PIX+x, x increments, and phase increments modulo HDEC on every accepted pixel.
REQ-023 din SHALL equal (luma>=THRESH) when WIDTH==1, else luma[7:8-WIDTH].
REQ-024 addr, din and we SHALL be registered: we is high exactly one cycle, the cycle after the qualifying dv, and low otherwise.
REQ-025 On an hblank rising edge in CAPTURE, if x>0 then y increments, and x and phase clear; a line with no writes does not advance y.
REQ-026 CAPTURE->DONE SHALL occur when y reaches V_LINES or on a vblank rising edge; no write occurs for y>=V_LINES.
REQ-027 DONE SHALL last one cycle with frame_done=1, then go to WAIT_FIELD if enable=1, else IDLE.
REQ-028 Deasserting enable during WAIT_FIELD SHALL return the FSM to IDLE; during CAPTURE, the current field completes first.
REQ-029 Edge detection SHALL use a registered copy of fvh; field==1 fields are never captured.
REQ-030 addr arithmetic SHALL be LOGSIZE bits with no wrap, guaranteed by REQ-004.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE; x, y, phase, addr, din, prev fvh = 0; we, busy, frame_done = 0.
REQ-032 Reset asserted mid-CAPTURE SHALL abort with no further writes; after release, capture restarts only via REQ-019/REQ-020.

Verification
REQ-033 Reset, enable=1, field0 v 1->0, 4 accepted pixels luma 200,10,200,200 at HDEC=2 -> we pulses twice, addr 0 then 1, din 1 then 1.
REQ-034 hblank rising after 3 writes -> next write addr=H_PIX (128), x restarts at 0; empty line -> y unchanged.
REQ-035 Field1 vblank falling edge in WAIT_FIELD -> stays WAIT_FIELD, busy=1, no we.
REQ-036 Full 128x128 frame -> last write addr 16383, frame_done one cycle, then WAIT_FIELD with enable=1, IDLE with enable=0.
REQ-037 dv=1 with h=1 in the same cycle -> no write; reset_n low mid-line -> we=0 immediately, state IDLE.
REQ-038 WIDTH=4, luma=8'hA7 -> din=4'hA.

Source files
------------

// File: rtl/ntsc_bram_writer.sv
// Captures decimated NTSC luma from even fields into a BRAM frame buffer.
// One write per kept pixel; addr/din/we are registered for the BRAM port.
module ntsc_bram_writer #(
   parameter int unsigned LOGSIZE = 14,
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned H_PIX   = 128,
   parameter int unsigned V_LINES = 128,
   parameter int unsigned HDEC    = 2,
   parameter logic [7:0]  THRESH  = 8'd128
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [7:0]         luma,
   input  logic               dv,
   input  logic [2:0]         fvh,
   output logic [LOGSIZE-1:0] addr,
   output logic [WIDTH-1:0]   din,
   output logic               we,
   output logic               busy,
   output logic               frame_done
);

   localparam int unsigned XW = $clog2(H_PIX + 1);
   localparam int unsigned YW = $clog2(V_LINES + 1);
   localparam int unsigned PW = (HDEC > 1) ? $clog2(HDEC) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_FIELD, CAPTURE, DONE} state_t;

   state_t             state_q, state_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic [2:0]         fvh_q, fvh_d;
   logic [LOGSIZE-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]   din_q, din_d;
   logic               we_q, we_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               v_fall, v_rise, h_rise, pix_ok;
   logic [WIDTH-1:0]   pix_val;

   always_comb begin
      v_fall = fvh_q[1] & ~fvh[1];
      v_rise = ~fvh_q[1] & fvh[1];
      h_rise = ~fvh_q[0] & fvh[0];
      pix_ok = dv & ~fvh[1] & ~fvh[0];
      if (WIDTH == 1) pix_val = WIDTH'(luma >= THRESH);
      else            pix_val = luma[7 -: WIDTH];
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      phase_d = phase_q;
      fvh_d   = fvh;
      addr_d  = addr_q;
      din_d   = din_q;
      we_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_FIELD;
         end
         WAIT_FIELD: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (v_fall && !fvh[2]) begin
               state_d = CAPTURE;
               x_d     = '0;
               y_d     = '0;
               phase_d = '0;
            end
         end
         CAPTURE: begin
            if (v_rise) begin
               state_d = DONE;
            end else if (h_rise) begin
               // Blank lines (no writes yet) must not consume a frame row.
               if (x_q != '0) y_d = y_q + 1'b1;
               x_d     = '0;
               phase_d = '0;
               if (y_d == YW'(V_LINES)) state_d = DONE;
            end else if (pix_ok) begin
               if (phase_q == '0 && x_q < XW'(H_PIX) && y_q < YW'(V_LINES)) begin
                  we_d   = 1'b1;
                  addr_d = LOGSIZE'(y_q) * LOGSIZE'(H_PIX) + LOGSIZE'(x_q);
                  din_d  = pix_val;
                  x_d    = x_q + 1'b1;
               end
               phase_d = (phase_q == PW'(HDEC - 1)) ? '0 : phase_q + 1'b1;
            end
         end
         DONE: begin
            state_d = enable ? WAIT_FIELD : IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == WAIT_FIELD) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         phase_q <= '0;
         fvh_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         phase_q <= phase_d;
         fvh_q   <= fvh_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign addr       = addr_q;
   assign din        = din_q;
   assign we         = we_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
